// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one fixed-latency single-ported memory between instruction fetch and data.
// Optional round-robin tie breaking via MEMARB_RR_EN; default build gives data fixed priority.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req (and its address/data) high until it sees
  // a one-cycle ready pulse; a req still high after the pulse is a new request.

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = data port, 0 = fetch port
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_d;
  logic        prio_d;

`ifdef MEMARB_RR_EN
  logic        last_q, last_d;     // last owner: 1 = data, 0 = fetch
  assign prio_d = ~last_q;
`else
  assign prio_d = 1'b1;
`endif

  assign grant_d = d_req & (~if_req | prio_d);

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEMARB_RR_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEMARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEMARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d = grant_d;
          addr_d  = grant_d ? d_addr : if_addr;
          wdata_d = grant_d ? d_wdata : 32'h0;
          we_d    = grant_d & d_we;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
`ifdef MEMARB_RR_EN
          last_d  = grant_d;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 8'd0) begin
          if (!we_q) begin
            if (owner_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_we    = we_q;
      mem_re    = ~we_q;
    end
    if_ready  = (state_q == DONE) & ~owner_q;
    d_ready   = (state_q == DONE) & owner_q;
    busy      = (state_q != IDLE);
    if_stall  = if_req & ~if_ready;
    d_stall   = d_req & ~d_ready;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, tie, store, mid-access reset, starvation.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        clear;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, if_stall, d_ready, d_stall, mem_we, mem_re, busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(2)) dut (
    .clock(clk), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check_eq({tag, "_mem_re"}, {31'b0, mem_re}, 32'h0);
    check_eq({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'h0);
    check_eq({tag, "_if_ready"}, {31'b0, if_ready}, 32'h0);
    check_eq({tag, "_d_ready"}, {31'b0, d_ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h90; d_addr = 32'h20; d_wdata = 32'h0; mem_rdata = 32'h0;

    // Reset held with both requests high
    repeat (2) begin
      nxt(); smp();
      check_quiet("rst");
      check_eq("rst_if_rdata", if_rdata, 32'h0);
      check_eq("rst_d_rdata", d_rdata, 32'h0);
    end
    nxt(); clear = 1'b1;
    smp(); check_eq("rel_idle_busy", {31'b0, busy}, 32'h0);
    nxt(); smp();
    check_eq("rel_grant_busy", {31'b0, busy}, 32'h1);
    check_eq("rel_grant_addr", mem_addr, 32'h20);
    check_eq("rel_grant_re", {31'b0, mem_re}, 32'h1);

    // Reset during ACCESS cycle 1: abandoned, never completes
    clear = 1'b0; if_req = 1'b0; d_req = 1'b0;
    nxt(); smp();
    check_quiet("midrst");
    nxt(); clear = 1'b1;
    repeat (5) begin
      smp();
      check_eq("midrst_no_ready", {31'b0, d_ready}, 32'h0);
      check_eq("midrst_idle", {31'b0, busy}, 32'h0);
      nxt();
    end

    // Single fetch
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    smp();
    check_eq("fetch_c0_stall", {31'b0, if_stall}, 32'h1);
    check_eq("fetch_c0_re", {31'b0, mem_re}, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      nxt(); smp();
      check_eq("fetch_acc_re", {31'b0, mem_re}, 32'h1);
      check_eq("fetch_acc_we", {31'b0, mem_we}, 32'h0);
      check_eq("fetch_acc_addr", mem_addr, 32'h10);
      check_eq("fetch_acc_stall", {31'b0, if_stall}, 32'h1);
    end
    nxt(); smp();
    check_eq("fetch_ready", {31'b0, if_ready}, 32'h1);
    check_eq("fetch_rdata", if_rdata, 32'hDEADBEEF);
    check_eq("fetch_stall_lo", {31'b0, if_stall}, 32'h0);
    check_eq("fetch_done_re", {31'b0, mem_re}, 32'h0);
    nxt(); if_req = 1'b0;
    smp();
    check_eq("fetch_after_ready", {31'b0, if_ready}, 32'h0);
    check_eq("fetch_after_busy", {31'b0, busy}, 32'h0);

    // Tie: data first, fetch afterwards
    nxt();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; if_addr = 32'h30;
    mem_rdata = 32'hA5A50001;
    smp();
    check_eq("tie_d_stall", {31'b0, d_stall}, 32'h1);
    check_eq("tie_if_stall", {31'b0, if_stall}, 32'h1);
    for (int c = 1; c <= 2; c++) begin
      nxt(); smp();
      check_eq("tie_d_addr", mem_addr, 32'h20);
      check_eq("tie_d_re", {31'b0, mem_re}, 32'h1);
    end
    nxt(); smp();
    check_eq("tie_d_ready", {31'b0, d_ready}, 32'h1);
    check_eq("tie_d_rdata", d_rdata, 32'hA5A50001);
    check_eq("tie_if_not_ready", {31'b0, if_ready}, 32'h0);
    check_eq("tie_if_still_stall", {31'b0, if_stall}, 32'h1);
    nxt(); d_req = 1'b0; mem_rdata = 32'h0BADF00D;
    smp();
    check_eq("tie_c4_busy", {31'b0, busy}, 32'h0);
    for (int c = 5; c <= 6; c++) begin
      nxt(); smp();
      check_eq("tie_if_addr", mem_addr, 32'h30);
    end
    nxt(); smp();
    check_eq("tie_if_ready", {31'b0, if_ready}, 32'h1);
    check_eq("tie_if_rdata", if_rdata, 32'h0BADF00D);
    check_eq("tie_d_rdata_hold", d_rdata, 32'hA5A50001);
    nxt(); if_req = 1'b0;

    // Store
    nxt();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234; mem_rdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 2; c++) begin
      nxt(); smp();
      check_eq("st_we", {31'b0, mem_we}, 32'h1);
      check_eq("st_re", {31'b0, mem_re}, 32'h0);
      check_eq("st_addr", mem_addr, 32'h40);
      check_eq("st_wdata", mem_wdata, 32'h1234);
    end
    nxt(); smp();
    check_eq("st_ready", {31'b0, d_ready}, 32'h1);
    check_eq("st_rdata_hold", d_rdata, 32'hA5A50001);
    check_eq("st_done_we", {31'b0, mem_we}, 32'h0);
    nxt(); d_req = 1'b0; d_we = 1'b0;

    // Starvation after a fresh reset, both requests held
    nxt(); clear = 1'b0;
    nxt(); clear = 1'b1;
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h80; if_addr = 32'h90;
`ifdef MEMARB_RR_EN
    exp_q.push_back(32'h80); exp_q.push_back(32'h90);
    exp_q.push_back(32'h80); exp_q.push_back(32'h90);
`else
    repeat (4) exp_q.push_back(32'h80);
`endif
    for (int c = 0; c < 16; c++) begin
      if (c > 0) nxt();
      smp();
      if (c % 4 == 1 && exp_q.size() > 0) check_eq("starve_grant", mem_addr, exp_q.pop_front());
    end
    check_eq("starve_q_empty", exp_q.size(), 32'h0);
    nxt(); if_req = 1'b0; d_req = 1'b0;
    repeat (4) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
